// File: rtl/aes256_pkg.sv
// Shared types, constants and AES-256 datapath functions for the iterative encryptor.
// The S-box is computed as GF(2^8) inversion followed by the affine map.
package aes256_pkg;

  localparam int          BLK_W     = 128;
  localparam int          KEY_W     = 256;
  localparam logic [3:0]  NR        = 4'd14;
  localparam logic [31:0] RCON_INIT = 32'h01000000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      p  = b[i] ? (p ^ aa) : p;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // b^254 is the multiplicative inverse in GF(2^8), and maps 0 to 0.
  function automatic logic [7:0] gf_inv(input logic [7:0] b);
    logic [7:0] r;
    r = 8'h01;
    for (int i = 7; i >= 0; i--) begin
      r = gmul(r, r);
      r = (i != 0) ? gmul(r, b) : r;
    end
    return r;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [7:0] v;
    v = gf_inv(b);
    return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = 128'h0;
    for (int k = 0; k < 16; k++) o[8*k +: 8] = sbox(s[8*k +: 8]);
    return o;
  endfunction

  // Byte (row r, column c) lives at byte index 4c+r counted from the MSB.
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = 128'h0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[8*(15-(4*c+r)) +: 8] = s[8*(15-(4*((c+r)%4)+r)) +: 8];
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = 128'h0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[8*(15-4*c) +: 8];
      a1 = s[8*(14-4*c) +: 8];
      a2 = s[8*(13-4*c) +: 8];
      a3 = s[8*(12-4*c) +: 8];
      o[8*(15-4*c) +: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      o[8*(14-4*c) +: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      o[8*(13-4*c) +: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      o[8*(12-4*c) +: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return o;
  endfunction

  function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] k);
    return mix_columns(shift_rows(sub_bytes(s))) ^ k;
  endfunction

  function automatic logic [127:0] aes_lastround(input logic [127:0] s, input logic [127:0] k);
    return shift_rows(sub_bytes(s)) ^ k;
  endfunction

  // Advances the 8-word window by eight words: w[i..i+7] -> w[i+8..i+15].
  function automatic logic [255:0] key_expansion256(input logic [255:0] k, input logic [31:0] rcon);
    logic [31:0] n0, n1, n2, n3, n4, n5, n6, n7;
    n0 = k[255:224] ^ sub_word({k[23:0], k[31:24]}) ^ rcon;
    n1 = k[223:192] ^ n0;
    n2 = k[191:160] ^ n1;
    n3 = k[159:128] ^ n2;
    n4 = k[127:96]  ^ sub_word(n3);
    n5 = k[95:64]   ^ n4;
    n6 = k[63:32]   ^ n5;
    n7 = k[31:0]    ^ n6;
    return {n0, n1, n2, n3, n4, n5, n6, n7};
  endfunction

endpackage

// File: rtl/aes256_round_step.sv
// Combinational round step: picks the round flavour and key half from rnd and
// produces the next state, key window and rcon.
module aes256_round_step
  import aes256_pkg::*;
(
  input  logic [3:0]       rnd,
  input  logic [BLK_W-1:0] blk,
  input  logic [KEY_W-1:0] key,
  input  logic [31:0]      rcon,
  output logic [BLK_W-1:0] blk_next,
  output logic [KEY_W-1:0] key_next,
  output logic [31:0]      rcon_next
);

  logic [BLK_W-1:0] round_key_s;
  logic [BLK_W-1:0] round_s;
  logic [BLK_W-1:0] last_s;

  // Odd rounds use the low half and roll the key window forward.
  assign round_key_s = rnd[0] ? key[127:0] : key[255:128];
  assign round_s     = aes_round(blk, round_key_s);
  assign last_s      = aes_lastround(blk, key[255:128]);

  assign blk_next  = (rnd == NR) ? last_s : round_s;
  assign key_next  = rnd[0] ? key_expansion256(key, rcon) : key;
  assign rcon_next = rnd[0] ? {rcon[30:0], 1'b0} : rcon;

endmodule

// File: rtl/aes256_iter_ctrl.sv
// Iterative AES-256 encryptor: one round per clock over a rolling 256-bit key
// window, with valid/ready handshakes on the plaintext and ciphertext sides.
module aes256_iter_ctrl
  import aes256_pkg::*;
#(
  parameter bit BACK_TO_BACK = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [BLK_W-1:0] data_in,
  input  logic [KEY_W-1:0] key_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [BLK_W-1:0] data_out,
  output logic             busy
);

  state_e           fsm_r, fsm_nxt_s;
  logic [BLK_W-1:0] state_reg_r;
  logic [KEY_W-1:0] key_reg_r;
  logic [3:0]       rnd_r;
  logic [31:0]      rcon_r;
  logic             out_valid_r;
  logic [BLK_W-1:0] data_out_r;
  logic             busy_r;

  logic             in_ready_s;
  logic             accept_s;
  logic             finish_s;
  logic             release_s;
  logic [BLK_W-1:0] step_blk_s;
  logic [KEY_W-1:0] step_key_s;
  logic [31:0]      step_rcon_s;

  aes256_round_step u_step (
    .rnd       (rnd_r),
    .blk       (state_reg_r),
    .key       (key_reg_r),
    .rcon      (rcon_r),
    .blk_next  (step_blk_s),
    .key_next  (step_key_s),
    .rcon_next (step_rcon_s)
  );

  // Next-state decode and handshake strobes.
  always_comb begin
    fsm_nxt_s  = fsm_r;
    in_ready_s = 1'b0;
    accept_s   = 1'b0;
    finish_s   = 1'b0;
    release_s  = 1'b0;
    case (fsm_r)
      IDLE: begin
        in_ready_s = 1'b1;
        if (in_valid) begin
          accept_s  = 1'b1;
          fsm_nxt_s = RUN;
        end else begin
          fsm_nxt_s = IDLE;
        end
      end
      RUN: begin
        if (rnd_r == NR) begin
          finish_s  = 1'b1;
          fsm_nxt_s = DONE;
        end else begin
          fsm_nxt_s = RUN;
        end
      end
      DONE: begin
        in_ready_s = BACK_TO_BACK ? out_ready : 1'b0;
        if (out_ready) begin
          release_s = 1'b1;
          if (BACK_TO_BACK && in_valid) begin
            accept_s  = 1'b1;
            fsm_nxt_s = RUN;
          end else begin
            fsm_nxt_s = IDLE;
          end
        end else begin
          fsm_nxt_s = DONE;
        end
      end
      default: begin
        fsm_nxt_s = IDLE;
      end
    endcase
  end

  // State, datapath and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_r       <= IDLE;
      state_reg_r <= {BLK_W{1'b0}};
      key_reg_r   <= {KEY_W{1'b0}};
      rnd_r       <= 4'd0;
      rcon_r      <= RCON_INIT;
      out_valid_r <= 1'b0;
      data_out_r  <= {BLK_W{1'b0}};
      busy_r      <= 1'b0;
    end else begin
      fsm_r <= fsm_nxt_s;
      if (accept_s) begin
        state_reg_r <= data_in ^ key_in[255:128];
        key_reg_r   <= key_in;
        rnd_r       <= 4'd1;
        rcon_r      <= RCON_INIT;
        out_valid_r <= 1'b0;
        busy_r      <= 1'b1;
      end else if (finish_s) begin
        data_out_r  <= step_blk_s;
        out_valid_r <= 1'b1;
        busy_r      <= 1'b0;
      end else if (fsm_r == RUN) begin
        state_reg_r <= step_blk_s;
        key_reg_r   <= step_key_s;
        rcon_r      <= step_rcon_s;
        rnd_r       <= rnd_r + 4'd1;
      end else if (release_s) begin
        out_valid_r <= 1'b0;
      end
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_r;
  assign data_out  = data_out_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_aes256_iter_ctrl.sv
// Self-checking bench for aes256_iter_ctrl against a table-driven FIPS-197 model,
// with one instance per BACK_TO_BACK setting.
module tb_aes256_iter_ctrl;

  localparam logic [255:0] FIPS_KEY = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_CT  = 128'h8ea2b7ca516745bfeafc49904b496089;

  logic clk = 1'b0;
  logic rst, in_valid, out_ready, in_valid2, out_ready2;
  logic [127:0] data_in;
  logic [255:0] key_in;
  logic in_ready, out_valid, busy, in_ready2, out_valid2, busy2;
  logic [127:0] data_out, data_out2;

  int total = 0;
  int bad   = 0;
  logic [7:0] sbox_t [256];

  always #5 clk = ~clk;

  aes256_iter_ctrl #(.BACK_TO_BACK(1'b1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .data_in(data_in), .key_in(key_in), .out_valid(out_valid),
    .out_ready(out_ready), .data_out(data_out), .busy(busy)
  );

  aes256_iter_ctrl #(.BACK_TO_BACK(1'b0)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2),
    .data_in(data_in), .key_in(key_in), .out_valid(out_valid2),
    .out_ready(out_ready2), .data_out(data_out2), .busy(busy2)
  );

  function automatic logic [7:0] xt(input logic [7:0] b);
    return (b << 1) ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] rol8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  // S-box table from the generator/inverse-generator walk (p steps by 3, q by 1/3).
  task automatic build_sbox();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ (p << 1) ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ (q << 1);
      q = q ^ (q << 2);
      q = q ^ (q << 4);
      if (q[7]) q = q ^ 8'h09;
      x = q ^ rol8(q, 1) ^ rol8(q, 2) ^ rol8(q, 3) ^ rol8(q, 4);
      sbox_t[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sbox_t[0] = 8'h63;
  endtask

  function automatic logic [127:0] ref_encrypt(input logic [255:0] key, input logic [127:0] pt);
    logic [31:0]  w [60];
    logic [7:0]   s [4][4];
    logic [7:0]   t [4][4];
    logic [31:0]  tmp;
    logic [7:0]   rc;
    logic [127:0] res;
    for (int i = 0; i < 8; i++) w[i] = key[255 - 32*i -: 32];
    rc = 8'h01;
    for (int i = 8; i < 60; i++) begin
      tmp = w[i-1];
      if (i % 8 == 0) begin
        tmp = {sbox_t[tmp[23:16]], sbox_t[tmp[15:8]], sbox_t[tmp[7:0]], sbox_t[tmp[31:24]]} ^ {rc, 24'h0};
        rc  = xt(rc);
      end else if (i % 8 == 4) begin
        tmp = {sbox_t[tmp[31:24]], sbox_t[tmp[23:16]], sbox_t[tmp[15:8]], sbox_t[tmp[7:0]]};
      end
      w[i] = w[i-8] ^ tmp;
    end
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        s[r][c] = pt[127 - 8*(4*c+r) -: 8] ^ w[c][31 - 8*r -: 8];
    for (int rd = 1; rd <= 14; rd++) begin
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          t[r][c] = sbox_t[s[r][(c+r)%4]];
      for (int c = 0; c < 4; c++) begin
        if (rd < 14) begin
          s[0][c] = xt(t[0][c]) ^ xt(t[1][c]) ^ t[1][c] ^ t[2][c] ^ t[3][c];
          s[1][c] = t[0][c] ^ xt(t[1][c]) ^ xt(t[2][c]) ^ t[2][c] ^ t[3][c];
          s[2][c] = t[0][c] ^ t[1][c] ^ xt(t[2][c]) ^ xt(t[3][c]) ^ t[3][c];
          s[3][c] = xt(t[0][c]) ^ t[0][c] ^ t[1][c] ^ t[2][c] ^ xt(t[3][c]);
        end else begin
          for (int r = 0; r < 4; r++) s[r][c] = t[r][c];
        end
      end
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          s[r][c] ^= w[4*rd+c][31 - 8*r -: 8];
    end
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        res[127 - 8*(4*c+r) -: 8] = s[r][c];
    return res;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [255:0] rand256();
    return {rand128(), rand128()};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Advances up to 40 edges until the selected instance shows out_valid.
  task automatic wait_valid(input bit which, output int edges, output bit seen);
    edges = 0;
    seen  = 1'b0;
    while (!seen && edges < 40) begin
      tick();
      edges++;
      seen = which ? out_valid2 : out_valid;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    total++; if (out_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL reset_valid_busy: got %b/%b want 0/0", out_valid, busy); end
    total++; if (data_out !== 128'h0) begin bad++; $display("FAIL reset_data_out: got %h want 0", data_out); end
    total++; if (in_ready2 !== 1'b1 || out_valid2 !== 1'b0 || data_out2 !== 128'h0) begin
      bad++; $display("FAIL reset_dut2: got %b/%b/%h want 1/0/0", in_ready2, out_valid2, data_out2);
    end
    rst = 1'b0;
  endtask

  task automatic test_fips();
    int edges;
    bit seen;
    key_in   = FIPS_KEY;
    data_in  = FIPS_PT;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    total++; if (busy !== 1'b1 || in_ready !== 1'b0) begin bad++; $display("FAIL fips_busy: got busy=%b ready=%b want 1/0", busy, in_ready); end
    wait_valid(1'b0, edges, seen);
    total++; if (!seen || edges != 14) begin bad++; $display("FAIL fips_latency: got %0d cycles (seen=%b) want 15", edges + 1, seen); end
    total++; if (data_out !== FIPS_CT) begin bad++; $display("FAIL fips_data: got %h want %h", data_out, FIPS_CT); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL fips_busy_done: got %b want 0", busy); end
  endtask

  task automatic test_backpressure();
    in_valid = 1'b1;
    data_in  = rand128();
    for (int i = 0; i < 20; i++) begin
      tick();
      total++;
      if (out_valid !== 1'b1 || data_out !== FIPS_CT || in_ready !== 1'b0) begin
        bad++; $display("FAIL backpressure_hold[%0d]: got v=%b r=%b d=%h want 1/0/%h", i, out_valid, in_ready, data_out, FIPS_CT);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL backpressure_release: got %b want 0", out_valid); end
    total++; if (data_out !== FIPS_CT) begin bad++; $display("FAIL data_out_retain: got %h want %h", data_out, FIPS_CT); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL release_idle_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_back_to_back();
    logic [255:0] k;
    int res_t [2];
    logic [127:0] res_d [2];
    int n, got;
    k = rand256();
    res_t[0] = 0; res_t[1] = 0; res_d[0] = 128'h0; res_d[1] = 128'h0;
    key_in    = k;
    data_in   = 128'h0;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    tick();
    data_in = {128{1'b1}};
    n = 0;
    got = 0;
    while (got < 2 && n < 60) begin
      tick();
      n++;
      if (out_valid) begin
        res_t[got] = n;
        res_d[got] = data_out;
        got++;
        if (got == 2) in_valid = 1'b0;
      end
    end
    total++; if (got != 2) begin bad++; $display("FAIL b2b_count: got %0d results want 2", got); end
    total++; if (res_t[0] != 14) begin bad++; $display("FAIL b2b_latency: got %0d cycles want 15", res_t[0] + 1); end
    total++; if (res_t[1] - res_t[0] != 15) begin bad++; $display("FAIL b2b_spacing: got %0d want 15", res_t[1] - res_t[0]); end
    total++; if (res_d[0] !== ref_encrypt(k, 128'h0)) begin bad++; $display("FAIL b2b_data0: got %h want %h", res_d[0], ref_encrypt(k, 128'h0)); end
    total++; if (res_d[1] !== ref_encrypt(k, {128{1'b1}})) begin bad++; $display("FAIL b2b_data1: got %h want %h", res_d[1], ref_encrypt(k, {128{1'b1}})); end
    tick();
    out_ready = 1'b0;
    total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin bad++; $display("FAIL b2b_drain: got r=%b v=%b want 1/0", in_ready, out_valid); end
  endtask

  task automatic test_reset_mid();
    logic [255:0] k;
    logic [127:0] p;
    int edges;
    bit seen, any_valid;
    key_in   = rand256();
    data_in  = rand128();
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (6) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++; if (in_ready !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL midreset_idle: got r=%b busy=%b want 1/0", in_ready, busy); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL midreset_valid: got %b want 0", out_valid); end
    total++; if (data_out !== 128'h0) begin bad++; $display("FAIL midreset_data: got %h want 0", data_out); end
    any_valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      tick();
      any_valid = any_valid | out_valid;
    end
    total++; if (any_valid !== 1'b0) begin bad++; $display("FAIL midreset_no_emit: got %b want 0", any_valid); end
    k = rand256();
    p = rand128();
    key_in   = k;
    data_in  = p;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    wait_valid(1'b0, edges, seen);
    total++; if (!seen || data_out !== ref_encrypt(k, p)) begin bad++; $display("FAIL midreset_next: got %h (seen=%b) want %h", data_out, seen, ref_encrypt(k, p)); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_input_churn();
    logic [255:0] k;
    logic [127:0] p;
    int edges;
    bit seen;
    for (int it = 0; it < 3; it++) begin
      k = rand256();
      p = rand128();
      key_in   = k;
      data_in  = p;
      in_valid = 1'b1;
      tick();
      edges = 0;
      seen  = 1'b0;
      while (!seen && edges < 40) begin
        data_in  = rand128();
        key_in   = rand256();
        in_valid = 1'($urandom_range(1, 0));
        tick();
        edges++;
        seen = out_valid;
      end
      in_valid = 1'b0;
      total++; if (!seen || data_out !== ref_encrypt(k, p)) begin bad++; $display("FAIL churn[%0d]: got %h (seen=%b) want %h", it, data_out, seen, ref_encrypt(k, p)); end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
    end
  endtask

  task automatic test_no_back_to_back();
    logic [255:0] k;
    logic [127:0] p1, p2;
    int edges;
    bit seen;
    k  = rand256();
    p1 = rand128();
    p2 = rand128();
    key_in    = k;
    data_in   = p1;
    in_valid2 = 1'b1;
    tick();
    data_in = p2;
    wait_valid(1'b1, edges, seen);
    total++; if (!seen || edges != 14) begin bad++; $display("FAIL nob2b_latency: got %0d cycles (seen=%b) want 15", edges + 1, seen); end
    total++; if (data_out2 !== ref_encrypt(k, p1)) begin bad++; $display("FAIL nob2b_data1: got %h want %h", data_out2, ref_encrypt(k, p1)); end
    for (int i = 0; i < 3; i++) begin
      total++;
      if (in_ready2 !== 1'b0 || out_valid2 !== 1'b1) begin bad++; $display("FAIL nob2b_done_hold[%0d]: got r=%b v=%b want 0/1", i, in_ready2, out_valid2); end
      tick();
    end
    out_ready2 = 1'b1;
    tick();
    out_ready2 = 1'b0;
    total++; if (out_valid2 !== 1'b0 || in_ready2 !== 1'b1 || busy2 !== 1'b0) begin
      bad++; $display("FAIL nob2b_idle_gap: got v=%b r=%b busy=%b want 0/1/0", out_valid2, in_ready2, busy2);
    end
    tick();
    total++; if (busy2 !== 1'b1 || in_ready2 !== 1'b0) begin bad++; $display("FAIL nob2b_accept: got busy=%b r=%b want 1/0", busy2, in_ready2); end
    in_valid2 = 1'b0;
    wait_valid(1'b1, edges, seen);
    total++; if (!seen || data_out2 !== ref_encrypt(k, p2)) begin bad++; $display("FAIL nob2b_data2: got %h (seen=%b) want %h", data_out2, seen, ref_encrypt(k, p2)); end
    out_ready2 = 1'b1;
    tick();
    out_ready2 = 1'b0;
  endtask

  initial begin
    rst        = 1'b1;
    in_valid   = 1'b0;
    in_valid2  = 1'b0;
    out_ready  = 1'b0;
    out_ready2 = 1'b0;
    data_in    = 128'h0;
    key_in     = 256'h0;
    build_sbox();
    test_reset();
    test_fips();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_input_churn();
    test_no_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
